// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code decoder.
package johnson_pkg;

   typedef enum logic [1:0] {
      ACQ   = 2'd0,
      TRACK = 2'd1,
      ERR   = 2'd2
   } johnson_state_e;

   localparam int unsigned ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/johnson_code_chk.sv
// Combinational legality check and position decode of an N-bit Johnson code word.
module johnson_code_chk #(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = $clog2(2 * N)
) (
   input  logic [N-1:0]  q,
   output logic          legal,
   output logic [CW-1:0] idx
);

   logic [N-1:0]  thermo;
   logic [CW-1:0] pop;

   // Upper half of the cycle is the complement of a thermometer, so fold it first.
   always_comb begin
      thermo = q[N-1] ? ~q : q;
      legal  = ((thermo & (thermo + N'(1))) == '0);
      pop    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pop = pop + CW'(q[i]);
      end
      // Modulo-2^CW subtraction yields 2N - pop because pop >= 1 when q[N-1] = 1.
      idx = q[N-1] ? (CW'(2 * N) - pop) : pop;
   end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code position decoder with acquisition/tracking FSM and saturating error count.
// Optional registered one-hot position output when JOHNSON_DEC_ONEHOT_EN is defined.
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = $clog2(2 * N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         q_in,
   input  logic                 en,
   input  logic                 clr_err,
   output logic [CW-1:0]        idx,
   output logic                 idx_valid,
   output logic                 illegal,
   output logic                 seq_err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_cnt
`ifdef JOHNSON_DEC_ONEHOT_EN
   ,
   output logic [2*N-1:0]       onehot
`endif
);

   localparam int unsigned CODES = 2 * N;

   johnson_state_e        state_q, state_d, state_eval;
   logic [CW-1:0]         idx_q, idx_d, idx_next;
   logic                  idx_valid_q, idx_valid_d;
   logic                  illegal_q, illegal_d;
   logic                  seq_err_q, seq_err_d;
   logic                  locked_q, locked_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  err_inc;
   logic                  code_legal;
   logic [CW-1:0]         code_idx;

   johnson_code_chk #(
      .N  (N),
      .CW (CW)
   ) u_code_chk (
      .q     (q_in),
      .legal (code_legal),
      .idx   (code_idx)
   );

   // Next-state and output decode; clr_err makes the sample see ACQ and forces ACQ next.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      idx_valid_d = 1'b0;
      illegal_d   = 1'b0;
      seq_err_d   = 1'b0;
      err_inc     = 1'b0;
      err_cnt_d   = err_cnt_q;
      state_eval  = clr_err ? ACQ : state_q;
      idx_next    = (idx_q == CW'(CODES - 1)) ? '0 : (idx_q + CW'(1));

      if (en) begin
         if (!code_legal) begin
            illegal_d = 1'b1;
            err_inc   = 1'b1;
            if (state_eval == TRACK) begin
               state_d = ERR;
            end else begin
               state_d = state_eval;
            end
         end else begin
            idx_d       = code_idx;
            idx_valid_d = 1'b1;
            unique case (state_eval)
               ACQ:   state_d = TRACK;
               TRACK: begin
                  if ((code_idx != idx_q) && (code_idx != idx_next)) begin
                     seq_err_d = 1'b1;
                     err_inc   = 1'b1;
                     state_d   = ERR;
                  end
               end
               ERR:     state_d = ERR;
               default: state_d = ACQ;
            endcase
         end
      end

      if (clr_err) begin
         state_d   = ACQ;
         err_cnt_d = '0;
      end else if (err_inc && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end

      locked_d = (state_d == TRACK);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ACQ;
         idx_q       <= '0;
         idx_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         seq_err_q   <= 1'b0;
         locked_q    <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         idx_valid_q <= idx_valid_d;
         illegal_q   <= illegal_d;
         seq_err_q   <= seq_err_d;
         locked_q    <= locked_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign idx       = idx_q;
   assign idx_valid = idx_valid_q;
   assign illegal   = illegal_q;
   assign seq_err   = seq_err_q;
   assign locked    = locked_q;
   assign err_cnt   = err_cnt_q;

`ifdef JOHNSON_DEC_ONEHOT_EN
   logic [CODES-1:0] onehot_q, onehot_d;

   // One-hot tracks idx but is forced low whenever the decoder is not locked.
   always_comb begin
      onehot_d = '0;
      if (state_d == TRACK) begin
         onehot_d = CODES'(1) << idx_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         onehot_q <= '0;
      end else begin
         onehot_q <= onehot_d;
      end
   end

   assign onehot = onehot_q;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: directed scenarios plus randomized stimulus vs a table-driven model.
module tb_johnson_decoder;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int M  = 2 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  q_in;
   logic          en;
   logic          clr_err;
   logic [CW-1:0] idx;
   logic          idx_valid;
   logic          illegal;
   logic          seq_err;
   logic          locked;
   logic [7:0]    err_cnt;

   johnson_decoder #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .q_in      (q_in),
      .en        (en),
      .clr_err   (clr_err),
      .idx       (idx),
      .idx_valid (idx_valid),
      .illegal   (illegal),
      .seq_err   (seq_err),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // Reference: legal codes listed by running a Johnson counter from zero.
   int codes [M];
   int m_mode;   // 0 acquiring, 1 tracking, 2 error
   int m_idx, m_cnt, m_v, m_il, m_se;
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int lookup(input int q);
      for (int k = 0; k < M; k++) if (codes[k] == q) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_cnt = 0; m_v = 0; m_il = 0; m_se = 0;
   endtask

   task automatic model_step(input bit e, input int q, input bit c);
      int k, mode, nmode, inc;
      m_v = 0; m_il = 0; m_se = 0; inc = 0;
      nmode = m_mode;
      if (e) begin
         mode = c ? 0 : m_mode;
         nmode = mode;
         k = lookup(q);
         if (k < 0) begin
            m_il = 1; inc = 1;
            if (mode == 1) nmode = 2;
         end else begin
            m_v = 1;
            if (mode == 0) nmode = 1;
            else if (mode == 1 && k != m_idx && k != (m_idx + 1) % M) begin
               m_se = 1; inc = 1; nmode = 2;
            end
            m_idx = k;
         end
      end
      if (c) begin
         nmode = 0; m_cnt = 0;
      end else if (inc != 0 && m_cnt < 255) begin
         m_cnt++;
      end
      m_mode = nmode;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_idx"},     int'(idx),       m_idx);
      check({tag, "_valid"},   int'(idx_valid), m_v);
      check({tag, "_illegal"}, int'(illegal),   m_il);
      check({tag, "_seqerr"},  int'(seq_err),   m_se);
      check({tag, "_locked"},  int'(locked),    (m_mode == 1) ? 1 : 0);
      check({tag, "_errcnt"},  int'(err_cnt),   m_cnt);
   endtask

   // Called at a falling edge: drive, clock, update the model, then sample on the next falling edge.
   task automatic cycle(input bit e, input int q, input bit c, input string tag);
      en = e; q_in = N'(q); clr_err = c;
      @(posedge clk);
      model_step(e, q, c);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b0; en = 1'b0; clr_err = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic walk_to(input int k, input string tag);
      for (int i = 0; i <= k; i++) cycle(1'b1, codes[i], 1'b0, tag);
   endtask

   initial begin
      int c, q, r, kk;
      bit e, cl;
      c = 0;
      for (int k = 0; k < M; k++) begin
         codes[k] = c;
         c = ((c << 1) & ((1 << N) - 1)) | (((c >> (N - 1)) & 1) ^ 1);
      end
      rst = 1'b0; en = 1'b0; clr_err = 1'b0; q_in = '0;
      @(negedge clk);
      apply_reset("rst0");

      // Full cycle with wrap
      walk_to(M - 1, "walk");
      cycle(1'b1, 0, 1'b0, "wrap");
      check("wrap_idx0", int'(idx), 0);
      check("wrap_lock", int'(locked), 1);
      check("wrap_cnt0", int'(err_cnt), 0);

      // Illegal code while tracking
      apply_reset("rst1");
      walk_to(2, "pre_ill");
      cycle(1'b1, 'b0101, 1'b0, "ill");
      check("ill_pulse", int'(illegal), 1);
      check("ill_idx", int'(idx), 2);
      check("ill_cnt", int'(err_cnt), 1);
      check("ill_lock", int'(locked), 0);

      // Sequence jump, then recovery through clr_err
      apply_reset("rst2");
      walk_to(1, "pre_seq");
      cycle(1'b1, 'b1111, 1'b0, "seq");
      check("seq_pulse", int'(seq_err), 1);
      check("seq_idx", int'(idx), 4);
      check("seq_cnt", int'(err_cnt), 1);
      cycle(1'b1, 'b1111, 1'b1, "clr");
      check("clr_cnt", int'(err_cnt), 0);
      check("clr_unlock", int'(locked), 0);
      cycle(1'b1, 'b1110, 1'b0, "relock");
      check("relock_lock", int'(locked), 1);

      // Disabled sampling ignores garbage
      apply_reset("rst3");
      walk_to(3, "pre_hold");
      for (int i = 0; i < 5; i++) cycle(1'b0, 'b0101, 1'b0, "en0");
      cycle(1'b1, 'b0111, 1'b0, "hold");
      check("hold_valid", int'(idx_valid), 1);
      check("hold_idx", int'(idx), 3);
      check("hold_lock", int'(locked), 1);

      // Saturation and clear coincident with an illegal sample
      apply_reset("rst4");
      for (int i = 0; i < 300; i++) cycle(1'b1, 'b0101, 1'b0, "sat");
      check("sat_cnt", int'(err_cnt), 255);
      cycle(1'b1, 'b1010, 1'b1, "satclr");
      check("satclr_cnt", int'(err_cnt), 0);
      check("satclr_ill", int'(illegal), 1);
      check("satclr_lock", int'(locked), 0);

      // Asynchronous reset mid-tracking
      apply_reset("rst5");
      walk_to(6, "pre_rst");
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("arst_idx", int'(idx), 0);
      check("arst_lock", int'(locked), 0);
      model_reset();
      @(negedge clk);
      check_all("arst");
      rst = 1'b1;
      cycle(1'b1, 'b1100, 1'b0, "post_rst");
      check("post_idx", int'(idx), 6);
      check("post_lock", int'(locked), 1);

      // Randomized stimulus
      apply_reset("rst6");
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 399) == 0) apply_reset("rnd_rst");
         e  = ($urandom_range(0, 4) != 0);
         cl = e && ($urandom_range(0, 49) == 0);
         r  = int'($urandom_range(0, 99));
         if (r < 70) begin
            kk = (m_idx + int'($urandom_range(0, 1))) % M;
            q  = codes[kk];
         end else if (r < 85) begin
            q = codes[$urandom_range(0, M - 1)];
         end else begin
            q = int'($urandom_range(0, (1 << N) - 1));
         end
         cycle(e, q, cl, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
